// File: rtl/rpc_dev_pkg.sv
// rtl/rpc_dev_pkg.sv - shared types and command field layout for the RPC DRAM device responder
package rpc_dev_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_WR  = 2'b01,
        OP_RD  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD1,
        ST_WR_DATA,
        ST_RD_LAT,
        ST_RD_PRE,
        ST_RD_DATA,
        ST_RD_POST
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [5:0]  bl;
        logic [23:0] addr;
    } cmd_t;

    localparam int unsigned CMD_OP_MSB  = 15;
    localparam int unsigned CMD_OP_LSB  = 14;
    localparam int unsigned CMD_BL_MSB  = 13;
    localparam int unsigned CMD_BL_LSB  = 8;
    localparam int unsigned CMD_AHI_MSB = 7;
    localparam int unsigned CMD_AHI_LSB = 0;

    function automatic cmd_t decode_cmd(input logic [15:0] beat0, input logic [15:0] beat1);
        cmd_t c;
        c.op   = op_e'(beat0[CMD_OP_MSB:CMD_OP_LSB]);
        c.bl   = beat0[CMD_BL_MSB:CMD_BL_LSB];
        c.addr = {beat0[CMD_AHI_MSB:CMD_AHI_LSB], beat1};
        return c;
    endfunction

endpackage

// File: rtl/rpc_dev_if.sv
// rtl/rpc_dev_if.sv - device-side RPC pad bundle; the host drives csn/stb/dqs/db, the device drives the read side
interface rpc_dev_if;
    logic        csn;
    logic        stb;
    logic        dqs;
    logic [15:0] db_in;
    logic        oe_db;
    logic        oe_dqs;
    logic [15:0] db_out;
    logic        dqs_out;
    logic        dqsn_out;

    modport master (
        output csn, stb, dqs, db_in,
        input  oe_db, oe_dqs, db_out, dqs_out, dqsn_out
    );

    modport slave (
        input  csn, stb, dqs, db_in,
        output oe_db, oe_dqs, db_out, dqs_out, dqsn_out
    );
endinterface

// File: rtl/rpc_dev_responder.sv
// rtl/rpc_dev_responder.sv - RPC DRAM device emulator: two-beat command decode, dqs-strobed writes
// into a 1-cycle SRAM port, and read bursts driven back on db/dqs with output enables.
module rpc_dev_responder
    import rpc_dev_pkg::*;
#(
    parameter int unsigned AddrWidth   = 24,
    parameter int unsigned ReadLatency = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_csn_i,
    input  logic                 in_stb_i,
    input  logic                 in_dqs_i,
    input  logic [15:0]          in_db_i,
    output logic                 oe_db_o,
    output logic                 oe_dqs_o,
    output logic [15:0]          out_db_o,
    output logic                 out_dqs_o,
    output logic                 out_dqsn_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [15:0]          mem_wdata_o,
    input  logic [15:0]          mem_rdata_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam logic [3:0] LatLast = 4'(ReadLatency - 1);

    logic [15:0]          db_q;
    logic                 stb_q, csn_q, dqs_q, dqs_qq;
    state_e               state_q, state_d;
    logic [15:0]          beat0_q, beat0_d;
    logic [5:0]           bl_q, bl_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [3:0]           lat_q, lat_d;
    logic                 out_dqs_q, out_dqs_d;
    logic                 err_q, err_d;

    cmd_t                 cmd;
    logic                 dqs_edge;
    logic                 last_word;
    logic [AddrWidth-1:0] addr_cur, addr_nxt;

    assign cmd       = decode_cmd(beat0_q, db_q);
    assign dqs_edge  = dqs_q ^ dqs_qq;
    assign last_word = (cnt_q == bl_q);
    assign addr_cur  = base_q + AddrWidth'(cnt_q);
    assign addr_nxt  = base_q + AddrWidth'(cnt_q + 6'd1);

    always_comb begin
        state_d     = state_q;
        beat0_d     = beat0_q;
        bl_d        = bl_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        out_dqs_d   = out_dqs_q;
        err_d       = 1'b0;
        oe_db_o     = 1'b0;
        oe_dqs_o    = 1'b0;
        out_db_o    = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        // Deselect wins over everything else: outputs drop this cycle, no error is flagged.
        if (state_q != ST_IDLE && csn_q) begin
            state_d   = ST_IDLE;
            out_dqs_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!csn_q && stb_q) begin
                        beat0_d = db_q;
                        state_d = ST_CMD1;
                    end
                end
                ST_CMD1: begin
                    if (stb_q) begin
                        base_d = AddrWidth'(cmd.addr);
                        bl_d   = cmd.bl;
                        cnt_d  = '0;
                        lat_d  = '0;
                        case (cmd.op)
                            OP_WR:   state_d = ST_WR_DATA;
                            OP_RD:   state_d = ST_RD_LAT;
                            OP_NOP:  state_d = ST_IDLE;
                            default: begin
                                state_d = ST_IDLE;
                                err_d   = 1'b1;
                            end
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    if (dqs_edge) begin
                        mem_req_o   = 1'b1;
                        mem_we_o    = 1'b1;
                        mem_addr_o  = addr_cur;
                        mem_wdata_o = db_q;
                        if (last_word) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                end
                ST_RD_LAT: begin
                    if (lat_q == LatLast) begin
                        state_d = ST_RD_PRE;
                    end else begin
                        lat_d = lat_q + 4'd1;
                    end
                end
                ST_RD_PRE: begin
                    oe_db_o    = 1'b1;
                    oe_dqs_o   = 1'b1;
                    mem_req_o  = 1'b1;
                    mem_addr_o = base_q;
                    cnt_d      = '0;
                    out_dqs_d  = 1'b1;
                    state_d    = ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    // Word k is on the bus while word k+1 is fetched behind it.
                    oe_db_o  = 1'b1;
                    oe_dqs_o = 1'b1;
                    out_db_o = mem_rdata_i;
                    if (last_word) begin
                        state_d = ST_RD_POST;
                    end else begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = addr_nxt;
                        cnt_d      = cnt_q + 6'd1;
                        out_dqs_d  = ~out_dqs_q;
                    end
                end
                ST_RD_POST: begin
                    oe_db_o   = 1'b1;
                    oe_dqs_o  = 1'b1;
                    out_dqs_d = 1'b0;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    out_dqs_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            db_q      <= '0;
            stb_q     <= 1'b0;
            csn_q     <= 1'b0;
            dqs_q     <= 1'b0;
            dqs_qq    <= 1'b0;
            state_q   <= ST_IDLE;
            beat0_q   <= '0;
            bl_q      <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            out_dqs_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            db_q      <= in_db_i;
            stb_q     <= in_stb_i;
            csn_q     <= in_csn_i;
            dqs_q     <= in_dqs_i;
            dqs_qq    <= dqs_q;
            state_q   <= state_d;
            beat0_q   <= beat0_d;
            bl_q      <= bl_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            out_dqs_q <= out_dqs_d;
            err_q     <= err_d;
        end
    end

    assign out_dqs_o  = out_dqs_q;
    assign out_dqsn_o = ~out_dqs_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign err_o      = err_q;

endmodule

// File: tb/tb_rpc_dev_responder.sv
// tb/tb_rpc_dev_responder.sv - randomized write/read-back bench for rpc_dev_responder with an SRAM model
module tb_rpc_dev_responder;

    localparam int AW = 24;
    localparam int RL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_req, mem_we, busy, err;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    rpc_dev_if pads();

    rpc_dev_responder #(.AddrWidth(AW), .ReadLatency(RL)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_csn_i   (pads.csn),
        .in_stb_i   (pads.stb),
        .in_dqs_i   (pads.dqs),
        .in_db_i    (pads.db_in),
        .oe_db_o    (pads.oe_db),
        .oe_dqs_o   (pads.oe_dqs),
        .out_db_o   (pads.db_out),
        .out_dqs_o  (pads.dqs_out),
        .out_dqsn_o (pads.dqsn_out),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o     (busy),
        .err_o      (err)
    );

    // SRAM with one cycle of read latency; 12 index bits cover every address the bench uses.
    logic [15:0] sram [0:4095];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) sram[mem_addr[11:0]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[11:0]];
        end
    end

    typedef struct {
        int          c;
        logic        both;
        logic        dqs;
        logic [15:0] db;
    } oe_rec_t;

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, n_err = 0, n_req = 0, n_rdreq = 0, n_dqsn_bad = 0;
    logic [39:0] wr_log[$];
    oe_rec_t     oe_log[$];
    logic [15:0] ref_mem[int];
    logic [15:0] pat[$];

    initial begin
        oe_rec_t r;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_req) n_req++;
            if (mem_req && mem_we) wr_log.push_back({mem_addr, mem_wdata});
            if (mem_req && !mem_we) n_rdreq++;
            if (err) n_err++;
            if (pads.dqsn_out !== ~pads.dqs_out) n_dqsn_bad++;
            if (pads.oe_db || pads.oe_dqs) begin
                r.c    = cyc;
                r.both = pads.oe_db && pads.oe_dqs;
                r.dqs  = pads.dqs_out;
                r.db   = pads.db_out;
                oe_log.push_back(r);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    task automatic fill_rand(input int n);
        pat.delete();
        repeat (n) pat.push_back(16'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {pads.oe_db, pads.oe_dqs, pads.dqs_out, pads.dqsn_out,
                              mem_req, mem_we, busy, err}, 8'b0001_0000);
        check({tag, "_bus"}, {pads.db_out, mem_addr, mem_wdata}, 56'h0);
    endtask

    task automatic send_cmd(input logic [1:0] op, input int bl, input logic [23:0] addr, output int c1);
        pads.csn   = 1'b0;
        pads.stb   = 1'b1;
        pads.db_in = {op, 6'(bl), addr[23:16]};
        step();
        pads.db_in = addr[15:0];
        c1 = cyc;
        step();
        pads.stb   = 1'b0;
        pads.db_in = 16'h0;
    endtask

    // Writes pat[0..n-1]; when abort_at < n, csn rises together with one extra strobe.
    task automatic do_write(input logic [23:0] addr, input int n, input int abort_at);
        logic [39:0] exp_q[$];
        int          c1, a;
        wr_log.delete();
        send_cmd(2'b01, n - 1, addr, c1);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) break;
            repeat ($urandom_range(0, 2)) step();
            pads.db_in = pat[i];
            pads.dqs   = ~pads.dqs;
            step();
            a = int'((addr + 24'(i)) & 24'hFFFFFF);
            ref_mem[a] = pat[i];
            exp_q.push_back({24'(a), pat[i]});
        end
        if (abort_at < n) begin
            pads.csn   = 1'b1;
            pads.dqs   = ~pads.dqs;
            pads.db_in = 16'hDEAD;
            step();
            step();
            check("wr_abort_busy", busy, 1'b0);
        end else begin
            step();
            check("wr_end_busy", busy, 1'b0);
        end
        pads.csn = 1'b1;
        step();
        check("wr_count", wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check($sformatf("wr%0d@%0h", i, addr), wr_log[i], exp_q[i]);
    endtask

    // mode 0: full burst, 1: deselect after two data words, 2: reset after the first data word
    task automatic do_read(input logic [23:0] addr, input int n, input int mode);
        int   c1, rq0, rq_a, guard;
        logic edqs;
        logic [15:0] edb;
        oe_log.delete();
        rq0 = n_rdreq;
        send_cmd(2'b10, n - 1, addr, c1);
        guard = 0;
        while (busy && guard < n + RL + 10) begin
            if (mode == 1 && oe_log.size() == 3) begin
                pads.csn = 1'b1;
                rq_a = n_rdreq;
                step();
                check("rd_abort_oe", {pads.oe_db, pads.oe_dqs}, 2'b00);
                step();
                check("rd_abort_busy", busy, 1'b0);
                repeat (3) step();
                check("rd_abort_noreq", n_rdreq - rq_a, 0);
                check("rd_abort_words", oe_log.size(), 3);
                check("rd_abort_w0", oe_log[1].db, ref_rd(int'(addr)));
                check("rd_abort_w1", oe_log[2].db, ref_rd(int'((addr + 24'd1) & 24'hFFFFFF)));
                return;
            end
            if (mode == 2 && oe_log.size() == 2) begin
                rst_n = 1'b0;
                rq_a  = n_req;
                step();
                check_reset_outputs("rd_reset");
                rst_n    = 1'b1;
                pads.csn = 1'b1;
                repeat (3) step();
                check("rd_reset_noreq", n_req - rq_a, 0);
                check("rd_reset_busy", busy, 1'b0);
                return;
            end
            step();
            guard++;
        end
        check("rd_done", busy, 1'b0);
        pads.csn = 1'b1;
        step();
        check("rd_beats", oe_log.size(), n + 2);
        check("rd_reqs", n_rdreq - rq0, n);
        if (oe_log.size() > 0) check("rd_lat", oe_log[0].c - c1, RL + 2);
        for (int i = 0; i < oe_log.size() && i < n + 2; i++) begin
            if (i == 0)          begin edqs = 1'b0;            edb = 16'h0; end
            else if (i == n + 1) begin edqs = 1'(n % 2);       edb = 16'h0; end
            else begin
                edqs = 1'(i % 2);
                edb  = ref_rd(int'((addr + 24'(i - 1)) & 24'hFFFFFF));
            end
            check($sformatf("rd_beat%0d@%0h", i, addr),
                  {32'(oe_log[i].c - oe_log[0].c), oe_log[i].both, oe_log[i].dqs, oe_log[i].db},
                  {32'(i), 1'b1, edqs, edb});
        end
    endtask

    task automatic err_case(input string tag, input logic [15:0] b0, input bit drop_stb, input int exp_err);
        int e0, r0;
        e0 = n_err;
        r0 = n_req;
        pads.csn   = 1'b0;
        pads.stb   = 1'b1;
        pads.db_in = b0;
        step();
        if (!drop_stb) begin
            pads.db_in = 16'($urandom);
            step();
        end
        pads.stb   = 1'b0;
        pads.db_in = 16'h0;
        repeat (4) step();
        check({tag, "_err"}, n_err - e0, exp_err);
        check({tag, "_noreq"}, n_req - r0, 0);
        check({tag, "_idle"}, busy, 1'b0);
        pads.csn = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [23:0] a;
        int          n;
        pads.csn   = 1'b1;
        pads.stb   = 1'b0;
        pads.dqs   = 1'b0;
        pads.db_in = 16'h0;
        rst_n      = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        pat = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        do_write(24'h000010, 4, 4);
        do_read(24'h000010, 4, 0);

        fill_rand(2);
        do_write(24'hFFFFFF, 2, 2);
        do_read(24'hFFFFFF, 2, 0);

        err_case("rsv", 16'hC000, 1'b0, 1);
        err_case("stbdrop", 16'h4300, 1'b1, 1);
        err_case("nop", 16'h0000, 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            a = 24'($urandom_range(32'h100, 32'hE00));
            n = $urandom_range(1, 16);
            fill_rand(n);
            do_write(a, n, n);
            do_read(a, n, 0);
        end

        fill_rand(64);
        do_write(24'h000200, 64, 64);
        do_read(24'h000200, 64, 0);

        fill_rand(6);
        do_write(24'h000300, 6, 2);
        do_read(24'h000300, 2, 0);

        fill_rand(8);
        do_write(24'h000400, 8, 8);
        do_read(24'h000400, 8, 1);
        do_read(24'h000400, 8, 2);
        do_read(24'h000010, 4, 0);

        check("dqsn_complement", n_dqsn_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_fail);
        $finish;
    end

endmodule
